// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-port unified memory shared by instruction fetch and data access.
// Data wins contention; a streak counter forces a pending fetch through after MAX_DM_STREAK data grants.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_valid_o,
  output logic [31:0] if_data_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_wstrb_i,
  output logic        dm_valid_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DM_STREAK);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDmBusy} state_e;

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       drop_q, drop_d;
  logic       if_elig, dm_elig;
  logic       grant_if, grant_dm;
  logic       if_done, dm_done;

  // A requester in its valid cycle has just been served and must not be re-granted.
  assign if_elig = if_req_i & ~if_valid_o;
  assign dm_elig = dm_req_i & ~dm_valid_o;

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign dm_stall_o = dm_req_i & ~dm_valid_o;

  assign if_done = (state_q == StIfBusy) & mem_ready_i;
  assign dm_done = (state_q == StDmBusy) & mem_ready_i;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (dm_elig && (!if_elig || (streak_q < MaxStreak))) begin
          grant_dm = 1'b1;
          state_d  = StDmBusy;
          streak_d = if_elig ? streak_q + 4'd1 : 4'd0;
        end else if (if_elig) begin
          grant_if = 1'b1;
          state_d  = StIfBusy;
          streak_d = 4'd0;
        end
      end
      StIfBusy: begin
        if (if_flush_i) drop_d = 1'b1;
        if (mem_ready_i) state_d = StIdle;
      end
      StDmBusy: begin
        if (mem_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      streak_q <= 4'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
    end
  end

  // Command register: loaded on grant, held until the memory completes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_wstrb_o <= 4'h0;
    end else if (grant_if || grant_dm) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= grant_dm & dm_we_i;
      mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
      mem_wdata_o <= grant_dm ? dm_wdata_i : 32'h0;
      mem_wstrb_o <= grant_dm ? dm_wstrb_i : 4'h0;
    end else if (mem_req_o && mem_ready_i) begin
      mem_req_o <= 1'b0;
    end
  end

  // A flush on the ready cycle itself must also suppress the fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_o <= 1'b0;
      if_data_o  <= 32'h0;
      dm_valid_o <= 1'b0;
      dm_rdata_o <= 32'h0;
    end else begin
      if_valid_o <= if_done & ~(drop_q | if_flush_i);
      dm_valid_o <= dm_done;
      if (if_done && !(drop_q || if_flush_i)) if_data_o <= mem_rdata_i;
      if (dm_done && !mem_we_o) dm_rdata_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level arbitration model, memory model
// and response scoreboard checked by an independent monitor.
module tb_mem_port_arbiter;

  localparam int unsigned MaxStreak = 2;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_valid_o;
  logic [31:0] if_data_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_wstrb_i;
  logic        dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  mem_port_arbiter #(.MAX_DM_STREAK(MaxStreak)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .if_valid_o  (if_valid_o),
    .if_data_o   (if_data_o),
    .if_stall_o  (if_stall_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_wstrb_i  (dm_wstrb_i),
    .dm_valid_o  (dm_valid_o),
    .dm_rdata_o  (dm_rdata_o),
    .dm_stall_o  (dm_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        st;
    logic [31:0] data;
  } dm_exp_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] if_q[$];
  dm_exp_t     dm_q[$];
  logic [31:0] sim_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  // Stimulus knobs (percentages, max memory wait cycles)
  int p_if, p_dm, p_flush, wait_max;

  // Transaction-level model of the arbiter
  int          streak;
  int          n_forced;
  bit          m_busy, m_who_if, m_drop;
  bit          exp_ifv, exp_dmv;
  bit          rdy;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;

  bit          if_pend, dm_pend;
  logic [31:0] last_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Predicts the next cycle from the inputs just driven and the current model state.
  task automatic predict();
    bit cur_ifv, cur_dmv, ife, dme;
    cur_ifv = exp_ifv;
    cur_dmv = exp_dmv;
    exp_ifv = 1'b0;
    exp_dmv = 1'b0;
    if (!m_busy) begin
      ife = if_req_i && !cur_ifv;
      dme = dm_req_i && !cur_dmv;
      m_drop = 1'b0;
      if (dme && (!ife || streak < int'(MaxStreak))) begin
        m_busy = 1'b1; m_who_if = 1'b0;
        streak = ife ? streak + 1 : 0;
        c_we = dm_we_i; c_addr = dm_addr_i; c_wdata = dm_wdata_i; c_wstrb = dm_wstrb_i;
      end else if (ife) begin
        if (dme) n_forced++;
        m_busy = 1'b1; m_who_if = 1'b1; streak = 0;
        c_we = 1'b0; c_addr = if_addr_i;
      end
    end else begin
      if (m_who_if && if_flush_i) m_drop = 1'b1;
      if (rdy) begin
        m_busy  = 1'b0;
        exp_ifv = m_who_if && !m_drop;
        exp_dmv = !m_who_if;
      end
    end
  endtask

  task automatic step();
    chk("if_valid", 32'(if_valid_o), 32'(exp_ifv));
    chk("dm_valid", 32'(dm_valid_o), 32'(exp_dmv));
    chk("mem_req", 32'(mem_req_o), 32'(m_busy));
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, c_addr);
      chk("mem_we", 32'(mem_we_o), 32'(c_we));
      if (!m_who_if) begin
        chk("mem_wdata", mem_wdata_o, c_wdata);
        chk("mem_wstrb", 32'(mem_wstrb_o), 32'(c_wstrb));
      end
    end
    // Memory side
    rdy = m_busy && ($urandom_range(0, wait_max) == 0);
    mem_ready_i = rdy;
    if (rdy) begin
      mem_rdata_i = sim_rd(mem_addr_o);
      if (mem_we_o) sim_mem[mem_addr_o] = merge(sim_rd(mem_addr_o), mem_wdata_o, mem_wstrb_o);
    end else begin
      mem_rdata_i = $urandom();
    end
    // Fetch requester
    if_flush_i = 1'b0;
    if (if_valid_o) if_pend = 1'b0;
    if (dm_valid_o) dm_pend = 1'b0;
    if (!if_pend && $urandom_range(0, 99) < p_if) begin
      if_pend   = 1'b1;
      if_addr_i = {16'h0, 14'($urandom()), 2'b00};
      if_q.push_back(ref_rd(if_addr_i));
    end else if ($urandom_range(0, 99) < p_flush) begin
      if_flush_i = 1'b1;
      if (if_pend) begin
        if_pend = 1'b0;
        void'(if_q.pop_back());
      end
    end
    if_req_i = if_pend;
    // Data requester
    if (!dm_pend) begin
      dm_we_i    = 1'($urandom());
      dm_addr_i  = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
      dm_wdata_i = $urandom();
      dm_wstrb_i = 4'($urandom());
      if ($urandom_range(0, 99) < p_dm) begin
        dm_pend = 1'b1;
        if (dm_we_i) begin
          ref_mem[dm_addr_i] = merge(ref_rd(dm_addr_i), dm_wdata_i, dm_wstrb_i);
          dm_q.push_back('{st: 1'b1, data: last_ld});
        end else begin
          last_ld = ref_rd(dm_addr_i);
          dm_q.push_back('{st: 1'b0, data: last_ld});
        end
      end
    end
    dm_req_i = dm_pend;
    predict();
  endtask

  task automatic run_phase(input int cycles, input int pi, input int pd, input int pf,
                           input int wm);
    p_if = pi; p_dm = pd; p_flush = pf; wait_max = wm;
    repeat (cycles) begin
      @(negedge clk);
      step();
    end
  endtask

  // Response monitor
  initial begin
    dm_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("if_stall", 32'(if_stall_o), 32'(if_req_i & ~if_valid_o));
      chk("dm_stall", 32'(dm_stall_o), 32'(dm_req_i & ~dm_valid_o));
      chk("valid_excl", 32'(if_valid_o & dm_valid_o), 32'd0);
      if (if_valid_o) begin
        chk("if_outstanding", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) chk("if_data", if_data_o, if_q.pop_front());
      end
      if (dm_valid_o) begin
        chk("dm_outstanding", 32'(dm_q.size() != 0), 32'd1);
        if (dm_q.size() != 0) begin
          e = dm_q.pop_front();
          chk(e.st ? "dm_rdata_store" : "dm_rdata_load", dm_rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; dm_wstrb_i = 4'h0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    streak = 0; n_forced = 0; m_busy = 1'b0; m_who_if = 1'b0; m_drop = 1'b0;
    exp_ifv = 1'b0; exp_dmv = 1'b0; rdy = 1'b0; if_pend = 1'b0; dm_pend = 1'b0;
    last_ld = 32'h0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_if_valid", 32'(if_valid_o), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid_o), 32'd0);
    chk("rst_if_data", if_data_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    rst = 1'b0;

    // Load held in DM_BUSY, then reset asynchronously mid-transaction.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h1000_0010;
    @(negedge clk);
    chk("busy_mem_req", 32'(mem_req_o), 32'd1);
    chk("busy_mem_addr", mem_addr_o, 32'h1000_0010);
    #1 rst = 1'b1;
    #1;
    chk("async_mem_req", 32'(mem_req_o), 32'd0);
    chk("async_if_valid", 32'(if_valid_o), 32'd0);
    chk("async_dm_valid", 32'(dm_valid_o), 32'd0);
    chk("async_mem_addr", mem_addr_o, 32'h0);
    chk("async_dm_rdata", dm_rdata_o, 32'h0);
    dm_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First fetch after reset at address 0; the model expects a grant next cycle.
    p_if = 0; p_dm = 0; p_flush = 0; wait_max = 0;
    if_pend = 1'b1; if_addr_i = 32'h0; if_req_i = 1'b1;
    if_q.push_back(ref_rd(32'h0));
    predict();

    run_phase(400, 30, 30, 10, 2);
    run_phase(300, 100, 100, 0, 0);
    run_phase(400, 60, 70, 15, 3);
    run_phase(200, 100, 100, 5, 1);
    run_phase(40, 0, 0, 0, 3);

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
    $display("Forced fetch grants observed: %0d", n_forced);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
